// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width and operand type for the load-datapath adders
package adder_pkg;
  localparam int unsigned ADD_WIDTH = 8;
  typedef logic [ADD_WIDTH-1:0] operand_t;
endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - one-bit full adder cell, purely combinational
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (p & ci);
endmodule

// File: rtl/full_adder8_reg.sv
// rtl/full_adder8_reg.sv - registered WIDTH-bit ripple-carry adder
// c_out is exported so two instances can be chained into a wider sum.
module full_adder8_reg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fa_bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Outputs only move on a valid capture, so X on idle operands never reaches them.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    v_d = in_valid;
    if (in_valid) begin
      s_d = sum;
      c_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_q;
  assign out_valid = v_q;
endmodule

// File: tb/tb_full_adder8_reg.sv
// tb/tb_full_adder8_reg.sv - directed-vector bench for full_adder8_reg
module tb_full_adder8_reg;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst_n, in_valid, c_in, out_valid, c_out;
  operand_t a, b, s;

  logic     in_valid_lo, c_in_lo, ov_lo, co_lo, ov_hi, co_hi;
  operand_t a_lo, b_lo, s_lo, a_hi, b_hi, s_hi;

  int total = 0;
  int bad   = 0;

  full_adder8_reg #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .s(s), .c_out(c_out)
  );

  full_adder8_reg #(.WIDTH(8)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_lo), .a(a_lo), .b(b_lo), .c_in(c_in_lo),
    .out_valid(ov_lo), .s(s_lo), .c_out(co_lo)
  );

  full_adder8_reg #(.WIDTH(8)) u_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(ov_lo), .a(a_hi), .b(b_hi), .c_in(co_lo),
    .out_valid(ov_hi), .s(s_hi), .c_out(co_hi)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic vv);
    a = av; b = bv; c_in = cv; in_valid = vv;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    chk({tag, ".s"}, s, es);
    chk({tag, ".c_out"}, c_out, ec);
    chk({tag, ".valid"}, out_valid, ev);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic c; logic [7:0] s; logic co; } vec_t;
  vec_t vecs [5];
  logic [8:0] ref_sum;
  logic       ref_v;
  logic [7:0] ref_s;
  logic       ref_c;

  initial begin
    vecs[0] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
    vecs[1] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0};
    vecs[3] = '{8'd127, 8'd128, 1'b1, 8'd0,   1'b1};
    vecs[4] = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1};

    rst_n = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    in_valid_lo = 1'b0; c_in_lo = 1'b0; a_lo = '0; b_lo = '0; a_hi = '0; b_hi = '0;

    // Reset held with operands toggling
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      expect_out("reset_hold", 8'd0, 1'b0, 1'b0);
    end

    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("release.valid", out_valid, 1'b0);

    drive(8'd15, 8'd4, 1'b0, 1'b1);
    tick();
    expect_out("nominal", 8'd19, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    expect_out("nominal_hold", 8'd19, 1'b0, 1'b0);

    a = 'x; b = 'x; c_in = 1'bx; in_valid = 1'b0;
    tick();
    expect_out("x_idle", 8'd19, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, 1'b1);
    end
    in_valid = 1'b0;
    tick();

    drive(8'd1, 8'd2, 1'b0, 1'b1);
    tick();
    expect_out("stream0", 8'd3, 1'b0, 1'b1);
    drive(8'd100, 8'd50, 1'b0, 1'b1);
    tick();
    expect_out("stream1", 8'd150, 1'b0, 1'b1);
    drive(8'd200, 8'd100, 1'b0, 1'b1);
    tick();
    expect_out("stream2", 8'd44, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("stream_end.valid", out_valid, 1'b0);

    // Asynchronous assertion mid-cycle, then a result in flight is dropped
    drive(8'd10, 8'd20, 1'b0, 1'b1);
    tick();
    expect_out("pre_reset", 8'd30, 1'b0, 1'b1);
    drive(8'd50, 8'd50, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_assert", 8'd0, 1'b0, 1'b0);
    tick();
    expect_out("reset_inflight", 8'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_out("after_release", 8'd0, 1'b0, 1'b0);

    // Chained pair: low-stage carry feeds the high stage one cycle later
    a_lo = 8'h0F; b_lo = 8'hF4; c_in_lo = 1'b0; in_valid_lo = 1'b1;
    a_hi = 8'h10; b_hi = 8'h20;
    tick();
    chk("chain_lo.s", s_lo, 8'h03);
    chk("chain_lo.c_out", co_lo, 1'b1);
    in_valid_lo = 1'b0;
    tick();
    chk("chain_hi.s", s_hi, 8'h31);
    chk("chain_hi.c_out", co_hi, 1'b0);
    chk("chain_hi.valid", ov_hi, 1'b1);
    a_lo = 8'h01; b_lo = 8'h02; in_valid_lo = 1'b1;
    tick();
    in_valid_lo = 1'b0;
    tick();
    chk("chain_hi_nc.s", s_hi, 8'h30);
    chk("chain_hi_nc.valid", ov_hi, 1'b1);

    ref_s = s;
    ref_c = c_out;
    for (int i = 0; i < 1000; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      ref_v   = in_valid;
      ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
      if (ref_v) begin
        ref_s = ref_sum[7:0];
        ref_c = ref_sum[8];
      end
      tick();
      expect_out("random", ref_s, ref_c, ref_v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
